// File: rtl/matmul_pkg.sv
// Shared types and constants for the systolic matmul sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matmul_pkg;

  localparam int MAX_DIM = 4;
  localparam int DIM_W   = $clog2(MAX_DIM + 1);
  localparam int CNT_W   = $clog2(2 * MAX_DIM + 1);

  typedef logic [DIM_W-1:0] dim_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    WB,
    DONE
  } matmul_ctrl_state_e;

  // Cycles the array must stay enabled after the last operand read:
  // one for the read latency plus (n-1)+(m-1) cycles of skew.
  function automatic cnt_t drain_len(input cnt_t n, input cnt_t m);
    return n + m - cnt_t'(1);
  endfunction

endpackage

// File: rtl/matmul_step_cnt.sv
// Up-counter with terminal-count flag, shared by the FEED/DRAIN/WB phases.
// Latency: count updates one cycle after en; last is decoded from the count register.
// Backpressure: none; clr has priority over en.
module matmul_step_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  // Step count: cleared on reset/clr, incremented while enabled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == i_limit);

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the systolic matmul array: clear, feed K operand steps, drain, write N rows.
// Latency: CLEAR one cycle after start; done_o after 2+K+(N+M-1)+N cycles (one less with reuse).
// Backpressure: none; start_i is only sampled in IDLE and is dropped otherwise.
module matmul_seq_ctrl #(
  parameter int MAX_DIM = matmul_pkg::MAX_DIM,
  parameter int DIM_W   = $clog2(MAX_DIM + 1),
  parameter int CNT_W   = $clog2(2 * MAX_DIM + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             reuse_i,
  input  logic [DIM_W-1:0] n_dim_i,
  input  logic [DIM_W-1:0] k_dim_i,
  input  logic [DIM_W-1:0] m_dim_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             pe_clear_o,
  output logic             pe_en_o,
  output logic             op_rd_en_o,
  output logic [DIM_W-1:0] op_rd_addr_o,
  output logic             feed_valid_o,
  output logic             res_wr_en_o,
  output logic [DIM_W-1:0] res_row_o
);

  import matmul_pkg::*;

  localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);

  matmul_ctrl_state_e r_state;
  logic [DIM_W-1:0]   r_n;
  logic [DIM_W-1:0]   r_k;
  logic [DIM_W-1:0]   r_m;
  logic               r_err;
  logic               r_feed_vld;

  logic [CNT_W-1:0]   w_cnt;
  logic [CNT_W-1:0]   w_limit;
  logic [DIM_W-1:0]   w_cnt_idx;
  logic               w_cnt_last;
  logic               w_cnt_en;
  logic               w_cnt_clr;
  logic               w_dims_ok;

  assign w_dims_ok = (n_dim_i != '0) && (n_dim_i <= MAX_D) &&
                     (k_dim_i != '0) && (k_dim_i <= MAX_D) &&
                     (m_dim_i != '0) && (m_dim_i <= MAX_D);

  // The counter only runs in the three timed phases and restarts at every
  // phase boundary, so each phase sees 0..limit.
  assign w_cnt_en  = (r_state == FEED) || (r_state == DRAIN) || (r_state == WB);
  assign w_cnt_clr = !w_cnt_en || w_cnt_last;

  // Terminal count of the phase currently running
  always_comb begin
    w_limit = '0;
    case (r_state)
      FEED:    w_limit = CNT_W'(r_k) - CNT_W'(1);
      DRAIN:   w_limit = CNT_W'(drain_len(cnt_t'(r_n), cnt_t'(r_m))) - CNT_W'(1);
      WB:      w_limit = CNT_W'(r_n) - CNT_W'(1);
      default: w_limit = '0;
    endcase
  end

  matmul_step_cnt #(
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .i_clk   (clk_i),
    .i_rst   (rst_ni),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_limit (w_limit),
    .o_cnt   (w_cnt),
    .o_last  (w_cnt_last)
  );

  // Phase sequencing, dimension latch, error pulse and feed-valid delay
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      r_state    <= IDLE;
      r_n        <= '0;
      r_k        <= '0;
      r_m        <= '0;
      r_err      <= 1'b0;
      r_feed_vld <= 1'b0;
    end else begin
      r_err      <= 1'b0;
      // Operand buffers return data one cycle after the read.
      r_feed_vld <= (r_state == FEED);
      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (w_dims_ok) begin
              r_n     <= n_dim_i;
              r_k     <= k_dim_i;
              r_m     <= m_dim_i;
              r_state <= reuse_i ? FEED : CLEAR;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        CLEAR: r_state <= FEED;
        FEED:  if (w_cnt_last) r_state <= DRAIN;
        DRAIN: if (w_cnt_last) r_state <= WB;
        WB:    if (w_cnt_last) r_state <= DONE;
        DONE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_cnt_idx = DIM_W'(w_cnt);

  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE);
  assign err_o        = r_err;
  assign pe_clear_o   = (r_state == CLEAR);
  assign pe_en_o      = (r_state == FEED) || (r_state == DRAIN);
  assign op_rd_en_o   = (r_state == FEED);
  assign op_rd_addr_o = (r_state == FEED) ? w_cnt_idx : '0;
  assign feed_valid_o = r_feed_vld;
  assign res_wr_en_o  = (r_state == WB);
  assign res_row_o    = (r_state == WB) ? w_cnt_idx : '0;

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer for the systolic-array matmul datapath.
- On a start pulse it latches the matrix dimensions, clears the PE accumulators, and streams operand rows from the A/B operand buffers into the array.
- It then holds the array enabled for the propagation/drain window, writes result rows to the result buffer, and reports completion.
- Sits between the bus/register front-end and the PE array plus operand/result memories.

Parameters:
- MAX_DIM, 4, maximum supported N, K, M (array is MAX_DIM x MAX_DIM).
- DIM_W, $clog2(MAX_DIM+1), width of dimension inputs.
- CNT_W, $clog2(2*MAX_DIM+1), width of internal step counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  synchronous, active-high reset.
- start_i  in  1  start request pulse; sampled only in IDLE.
- reuse_i  in  1  1 = accumulate onto existing PE contents (skip clear).
- n_dim_i  in  DIM_W  rows of A / C.
- k_dim_i  in  DIM_W  shared inner dimension.
- m_dim_i  in  DIM_W  columns of B / C.
- busy_o  out  1  high in every non-IDLE state.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse on rejected start.
- pe_clear_o  out  1  clear all PE accumulators.
- pe_en_o  out  1  PE array shift/MAC enable.
- op_rd_en_o  out  1  read enable to A and B operand buffers.
- op_rd_addr_o  out  DIM_W  operand step index k.
- feed_valid_o  out  1  operand data on array inputs is valid; 0 means inject zeros.
- res_wr_en_o  out  1  result buffer write enable.
- res_row_o  out  DIM_W  result row index.

Behaviour:
- Reset: state=IDLE; all outputs 0; counters and latched dims 0. Reset mid-operation aborts immediately with no done_o; the next cycle is IDLE.
- All outputs are registered or decoded from state/counter registers only, never combinational from inputs.
- Operand buffer read latency is 1 cycle. feed_valid_o is op_rd_en_o delayed 1 cycle, so it is still high in the first DRAIN cycle.
- IDLE:
  - start_i=1 with all dims in 1..MAX_DIM: latch N, K, M; go to CLEAR if reuse_i=0, else FEED.
  - Any dim 0 or >MAX_DIM: err_o=1 next cycle; stay IDLE.
- CLEAR (1 cycle): pe_clear_o=1 -> FEED.
- FEED (K cycles):
  - op_rd_en_o=1, op_rd_addr_o=0..K-1, pe_en_o=1.
  - Counter reaching K-1 -> DRAIN.
- DRAIN (N+M-1 cycles):
  - pe_en_o=1, op_rd_en_o=0.
  - Covers the 1-cycle read latency plus (N-1)+(M-1) skew propagation.
  - -> WB.
- WB (N cycles): res_wr_en_o=1, res_row_o=0..N-1, pe_en_o=0 (array frozen) -> DONE.
- DONE (1 cycle): done_o=1 -> IDLE.
- start_i outside IDLE is ignored; no queueing.
- Dimension inputs are don't-care after the latch.
- A start in the same cycle as done_o is ignored; a new start is accepted from the following IDLE cycle.
- Latency: start sampled at edge 0 puts CLEAR in cycle 1. done_o falls in cycle 1+1+K+(N+M-1)+N, or one cycle less when reuse_i=1.
- Counter resets to 0 on every state transition; no wrap beyond CNT_W, since the maximum count is 2*MAX_DIM-2.

Decomposition:
- matmul_pkg:
  - MAX_DIM default constant.
  - Enum matmul_ctrl_state_e {IDLE, CLEAR, FEED, DRAIN, WB, DONE}.
  - typedef dim_t.
  - Function drain_len(n,m)=n+m-1.
- One sub-module: matmul_step_cnt, a loadable up-counter with terminal-count flag (inputs clr, en, limit; output cnt, last), reused across FEED, DRAIN and WB.

Test Plan:
- N=K=M=4, reuse_i=0, start at cycle 0:
  - pe_clear_o in cycle 1.
  - op_rd_addr_o 0,1,2,3 in cycles 2-5.
  - feed_valid_o in cycles 3-6.
  - res_wr_en_o in cycles 13-16 with rows 0-3.
  - done_o in cycle 17; busy_o high in cycles 1-17.
- N=2, K=3, M=1: FEED cycles 2-4; DRAIN cycles 5-6; WB rows 0,1 in cycles 7-8; done_o in cycle 9.
- N=4, K=4, M=4, reuse_i=1: no pe_clear_o; FEED in cycles 1-4; done_o in cycle 16.
- k_dim_i=0 or n_dim_i=5: err_o pulse in cycle 1; busy_o stays 0; no memory accesses.
- start_i held high across a full run: exactly one operation per acceptance; second run's CLEAR appears 2 cycles after done_o.
- rst_ni asserted in the third FEED cycle: the next cycle has all outputs 0, state IDLE, no done_o. A subsequent start runs the full 17-cycle sequence.
